// File: rtl/mem_lsu.sv
// Load/store initiator: one aligned 32-bit bram access per request, lane masking and load extension.
// Latency: store done 2, load 3, illegal 1 cycle after accept; busy (ready=0) until done. Optional LSU_TIMEOUT_EN aborts a stalled read.
module mem_lsu #(
    parameter int AW      = 13,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [2:0]    funct3,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic          ready,
    output logic          done,
    output logic          err,
    output logic [31:0]   rdata,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rd_data,
    input  logic          mem_rd_valid,
    output logic          mem_wr_en,
    output logic [31:0]   mem_wr_data,
    output logic [3:0]    mem_wr_mask
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    logic       we_q;
    logic [2:0] f3_q;
    logic [1:0] off_q;
    logic       illegal;
    logic [31:0] st_data;
    logic [3:0]  st_mask;
    logic [31:0] ld_word;

    logic unused_bits;
    assign unused_bits = ^{addr[31:AW], 32'(TIMEOUT)};

`ifdef LSU_TIMEOUT_EN
    logic [$clog2(TIMEOUT+1)-1:0] wait_cnt;
`endif

    always_comb begin
        illegal = 1'b0;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
            illegal = 1'b1;
        if (we && funct3[2])
            illegal = 1'b1;
        if (funct3[1:0] == 2'b01 && addr[0])
            illegal = 1'b1;
        if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
            illegal = 1'b1;
    end

    // Lane k (bits [8k+7:8k], byte offset k) is enabled by mask bit 3-k.
    always_comb begin
        st_data = wdata;
        st_mask = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_data = {4{wdata[7:0]}};
                st_mask = 4'b1000 >> addr[1:0];
            end
            2'b01: begin
                st_data = {2{wdata[15:0]}};
                st_mask = addr[1] ? 4'b0011 : 4'b1100;
            end
            default: ;
        endcase
    end

    always_comb begin
        logic [31:0] sh8;
        logic [31:0] sh16;
        sh8  = mem_rd_data >> {off_q, 3'b000};
        sh16 = mem_rd_data >> {off_q[1], 4'b0000};
        case (f3_q)
            3'b000:  ld_word = {{24{sh8[7]}}, sh8[7:0]};
            3'b100:  ld_word = {24'd0, sh8[7:0]};
            3'b001:  ld_word = {{16{sh16[15]}}, sh16[15:0]};
            3'b101:  ld_word = {16'd0, sh16[15:0]};
            default: ld_word = mem_rd_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ready       <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            rdata       <= '0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_wr_mask <= '0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        ready <= 1'b0;
                        if (illegal) begin
                            state <= RESP;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            we_q     <= we;
                            f3_q     <= funct3;
                            off_q    <= addr[1:0];
                            mem_addr <= {addr[AW-1:2], 2'b00};
                            if (we) begin
                                mem_wr_en   <= 1'b1;
                                mem_wr_data <= st_data;
                                mem_wr_mask <= st_mask;
                            end else begin
                                mem_rd_en <= 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        state <= RESP;
                        done  <= 1'b1;
                        err   <= 1'b0;
                    end else begin
                        state <= WAIT;
`ifdef LSU_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (mem_rd_valid) begin
                        rdata <= ld_word;
                        state <= RESP;
                        done  <= 1'b1;
                        err   <= 1'b0;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_cnt == ($clog2(TIMEOUT+1))'(TIMEOUT-1)) begin
                        state <= RESP;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu against a 1-cycle-latency bram model.
module tb_mem_lsu;

    localparam int AW = 13;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rst, req, we;
    logic [2:0]    funct3;
    logic [31:0]   addr, wdata;
    logic          ready, done, err;
    logic [31:0]   rdata;
    logic          mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rd_data, mem_wr_data;
    logic          mem_rd_valid;
    logic [3:0]    mem_wr_mask;

    // bram model with a mute switch and a stray-return injector
    logic [31:0] mem [0:2047];
    logic        mdl_vld, mute, inj_vld;
    logic [31:0] mdl_dat, inj_dat;

    int passed = 0;
    int total  = 0;
    int lat, rd_cnt, wr_cnt;
    logic op_err;
    logic [31:0] addr_seen, wd_seen;
    logic [3:0]  mk_seen;

    always #5 clk = ~clk;

    assign mem_rd_valid = mdl_vld | inj_vld;
    assign mem_rd_data  = inj_vld ? inj_dat : mdl_dat;

    always @(posedge clk) begin
        mdl_vld <= 1'b0;
        if (mem_rd_en && !mute) begin
            mdl_vld <= 1'b1;
            mdl_dat <= mem[mem_addr[AW-1:2]];
        end
        if (mem_wr_en)
            for (int k = 0; k < 4; k++)
                if (mem_wr_mask[3-k])
                    mem[mem_addr[AW-1:2]][8*k +: 8] <= mem_wr_data[8*k +: 8];
    end

    mem_lsu #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
        .rdata(rdata), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask)
    );

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // lat = N means done is first seen in the N-th cycle after the accept edge
    task automatic do_op(input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d);
        req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
        step();
        req = 1'b0;
        lat = 99; rd_cnt = 0; wr_cnt = 0; op_err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_rd_en) begin rd_cnt++; addr_seen = 32'(mem_addr); end
            if (mem_wr_en) begin wr_cnt++; wd_seen = mem_wr_data; mk_seen = mem_wr_mask; end
            if (done) begin lat = i + 1; op_err = err; break; end
            step();
        end
        if (lat != 99) step();
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
        mute = 1'b0; inj_vld = 1'b0; inj_dat = '0;
        mem[4] = 32'h8899AABB;
        step(); step();
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_wr_bus", {mem_wr_data[27:0] | 28'(mem_addr), mem_wr_mask}, 32'd0);

        // word load
        do_op(1'b0, 3'b010, 32'h10, 32'h0);
        chk("lw_lat", lat, 3);
        chk("lw_err", 32'(op_err), 0);
        chk("lw_rd_cnt", rd_cnt, 1);
        chk("lw_wr_cnt", wr_cnt, 0);
        chk("lw_addr", addr_seen, 32'h010);
        chk("lw_rdata", rdata, 32'h8899AABB);
        chk("lw_ready", 32'(ready), 1);

        do_op(1'b0, 3'b000, 32'h13, 32'h0);
        chk("lb_rdata", rdata, 32'hFFFFFF88);
        do_op(1'b0, 3'b100, 32'h13, 32'h0);
        chk("lbu_rdata", rdata, 32'h00000088);
        do_op(1'b0, 3'b001, 32'h12, 32'h0);
        chk("lh_rdata", rdata, 32'hFFFF8899);
        do_op(1'b0, 3'b101, 32'h10, 32'h0);
        chk("lhu_rdata", rdata, 32'h0000AABB);

        // stores
        do_op(1'b1, 3'b000, 32'h11, 32'hFFFFFF5A);
        chk("sb_lat", lat, 2);
        chk("sb_wr_cnt", wr_cnt, 1);
        chk("sb_rd_cnt", rd_cnt, 0);
        chk("sb_data", wd_seen, 32'h5A5A5A5A);
        chk("sb_mask", 32'(mk_seen), 32'b0100);
        do_op(1'b1, 3'b001, 32'h12, 32'hABCD1234);
        chk("sh_data", wd_seen, 32'h12341234);
        chk("sh_mask", 32'(mk_seen), 32'b0011);
        do_op(1'b1, 3'b010, 32'h20, 32'hCAFEF00D);
        chk("sw_mask", 32'(mk_seen), 32'b1111);
        do_op(1'b0, 3'b010, 32'hFFFF0010, 32'h0);
        chk("lw_back_addr", addr_seen, 32'h010);
        chk("lw_back_rdata", rdata, 32'h12345ABB);

        // illegal requests
        do_op(1'b0, 3'b010, 32'h12, 32'h0);
        chk("ill_lw_lat", lat, 1);
        chk("ill_lw_err", 32'(op_err), 1);
        chk("ill_lw_strb", rd_cnt + wr_cnt, 0);
        do_op(1'b1, 3'b001, 32'h11, 32'h0);
        chk("ill_sh_lat", lat, 1);
        chk("ill_sh_err", 32'(op_err), 1);
        chk("ill_sh_strb", rd_cnt + wr_cnt, 0);
        do_op(1'b0, 3'b011, 32'h10, 32'h0);
        chk("ill_f3_err", 32'(op_err), 1);
        do_op(1'b1, 3'b100, 32'h10, 32'h0);
        chk("ill_sbu_err", 32'(op_err), 1);
        chk("ill_sbu_strb", rd_cnt + wr_cnt, 0);
        chk("ill_rdata", rdata, 32'h12345ABB);

        // reset while waiting for read data, then a stray return
        mute = 1'b1;
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h10;
        step();
        req = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_ready", 32'(ready), 1);
        chk("rstw_done", 32'(done), 0);
        inj_dat = 32'hDEADBEEF; inj_vld = 1'b1;
        step();
        inj_vld = 1'b0;
        chk("stray_done", 32'(done), 0);
        step();
        chk("stray_done2", 32'(done), 0);
        chk("stray_rdata", rdata, 32'h0);
        mute = 1'b0;
        do_op(1'b0, 3'b100, 32'h11, 32'h0);
        chk("recover_rdata", rdata, 32'h0000005A);

        // read that never returns
        mute = 1'b1;
        do_op(1'b0, 3'b010, 32'h10, 32'h0);
`ifdef LSU_TIMEOUT_EN
        chk("to_lat", lat, 2 + TIMEOUT);
        chk("to_err", 32'(op_err), 1);
        chk("to_rdata", rdata, 32'h0000005A);
`else
        chk("hang_no_done", lat, 99);
        chk("hang_busy", 32'(ready), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("hang_rst_ready", 32'(ready), 1);
`endif
        mute = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
